// File: rtl/uart_bridge_pkg.sv
// Shared types and helpers for the AXI-Stream to UART TX arbiter.
// Holds the FSM state type, the default header tag and the header-byte builder.
package uart_bridge_pkg;

  typedef enum logic {
    IDLE_ST,
    PAYLOAD_ST
  } arb_fsm_e;

  localparam logic [3:0] HEADER_TAG_DEFAULT = 4'hA;

  // Header byte: tag in the upper nibble, source port in the lower nibble.
  function automatic logic [7:0] buildHeader(input logic [3:0] tag, input logic [3:0] port);
    return {tag, port};
  endfunction

endpackage

// File: rtl/axis_uart_tx_arbiter_if.sv
// AXI-Stream byte bundle with N parallel lanes sharing one struct of signals.
// The master drives data/valid/last, the slave drives ready.
interface axis_uart_tx_arbiter_if #(
  parameter int N = 1
);
  logic [8*N-1:0] TDATA;
  logic [N-1:0]   TVALID;
  logic [N-1:0]   TLAST;
  logic [N-1:0]   TREADY;

  modport master (output TDATA, TVALID, TLAST, input TREADY);
  modport slave  (input TDATA, TVALID, TLAST, output TREADY);
endinterface

// File: rtl/axis_rr_arbiter_core.sv
// Combinational round-robin picker: first requesting port strictly after
// the last granted one, wrapping modulo N_PORTS.
module axis_rr_arbiter_core #(
  parameter int N_PORTS = 4
) (
  input  logic [N_PORTS-1:0] i_req,
  input  logic [3:0]         i_lastGrant,
  output logic [3:0]         o_winner,
  output logic               o_anyReq
);

  logic w_found;

  // Scan offsets 1..N_PORTS so the last granted port is considered last.
  always_comb begin
    int cand;
    cand     = 0;
    w_found  = 1'b0;
    o_winner = 4'd0;
    o_anyReq = |i_req;
    for (int off = 1; off <= N_PORTS; off++) begin
      cand = (int'(i_lastGrant) + off) % N_PORTS;
      for (int p = 0; p < N_PORTS; p++) begin
        if (!w_found && (p == cand) && i_req[p]) begin
          w_found  = 1'b1;
          o_winner = 4'(p);
        end
      end
    end
  end

endmodule

// File: rtl/axis_uart_tx_arbiter.sv
// Round-robin packet arbiter feeding the UART TX serializer: locks onto one
// source per packet and prefixes each frame with a one-byte channel header.
module axis_uart_tx_arbiter
  import uart_bridge_pkg::*;
#(
  parameter int         N_PORTS     = 4,
  parameter logic [3:0] HEADER_TAG  = HEADER_TAG_DEFAULT,
  parameter int         MAX_PAYLOAD = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  axis_uart_tx_arbiter_if.slave         s_axis,
  axis_uart_tx_arbiter_if.master        m_axis,
  output logic [3:0]                    GRANT_ID,
  output logic                          BUSY,
  output logic                          OVERSIZE
);

  localparam logic [15:0] LAST_IDX = 16'(MAX_PAYLOAD - 1);

  arb_fsm_e r_state, w_nextState;

  logic [3:0]  r_grant, r_lastGrant;
  logic [15:0] r_byteCnt;
  logic [7:0]  r_mData;
  logic        r_mLast, r_mValid, r_oversize;

  logic               w_slotFree, w_anyReq, w_loadHeader, w_accept;
  logic               w_capHit, w_byteLast, w_grantValid, w_grantLast;
  logic [3:0]         w_winner;
  logic [N_PORTS-1:0] w_grantMask;
  logic [7:0]         w_grantData;

  axis_rr_arbiter_core #(.N_PORTS(N_PORTS)) u_core (
    .i_req       (s_axis.TVALID),
    .i_lastGrant (r_lastGrant),
    .o_winner    (w_winner),
    .o_anyReq    (w_anyReq)
  );

  assign w_slotFree   = !r_mValid || m_axis.TREADY;
  assign w_grantMask  = N_PORTS'(1) << r_grant;
  assign w_grantValid = |(s_axis.TVALID & w_grantMask);
  assign w_grantLast  = |(s_axis.TLAST & w_grantMask);
  assign w_capHit     = (r_byteCnt == LAST_IDX);
  assign w_byteLast   = w_grantLast || w_capHit;

  always_comb begin
    w_grantData = 8'h00;
    for (int i = 0; i < N_PORTS; i++) begin
      if (4'(i) == r_grant) w_grantData = s_axis.TDATA[8*i +: 8];
    end
  end

  // Next-state and handshake decode; ready only ever points at the granted port.
  always_comb begin
    w_nextState   = r_state;
    w_loadHeader  = 1'b0;
    w_accept      = 1'b0;
    s_axis.TREADY = '0;
    unique case (r_state)
      IDLE_ST: begin
        if (w_slotFree && w_anyReq) begin
          w_loadHeader = 1'b1;
          w_nextState  = PAYLOAD_ST;
        end
      end
      PAYLOAD_ST: begin
        if (w_slotFree) s_axis.TREADY = w_grantMask;
        if (w_slotFree && w_grantValid) begin
          w_accept = 1'b1;
          if (w_byteLast) w_nextState = IDLE_ST;
        end
      end
      default: w_nextState = IDLE_ST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE_ST;
    else       r_state <= w_nextState;
  end

  // Output register, grant bookkeeping and payload counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant     <= 4'd0;
      r_lastGrant <= 4'(N_PORTS - 1);
      r_byteCnt   <= 16'd0;
      r_mData     <= 8'h00;
      r_mLast     <= 1'b0;
      r_mValid    <= 1'b0;
      r_oversize  <= 1'b0;
    end else begin
      r_oversize <= 1'b0;
      if (w_loadHeader) begin
        r_grant   <= w_winner;
        r_byteCnt <= 16'd0;
        r_mData   <= buildHeader(HEADER_TAG, w_winner);
        r_mLast   <= 1'b0;
        r_mValid  <= 1'b1;
      end else if (w_accept) begin
        r_mData    <= w_grantData;
        r_mLast    <= w_byteLast;
        r_mValid   <= 1'b1;
        r_byteCnt  <= r_byteCnt + 16'd1;
        r_oversize <= w_capHit && !w_grantLast;
        if (w_byteLast) r_lastGrant <= r_grant;
      end else if (w_slotFree) begin
        r_mValid <= 1'b0;
      end
    end
  end

  assign m_axis.TDATA  = r_mData;
  assign m_axis.TLAST  = r_mLast;
  assign m_axis.TVALID = r_mValid;
  assign GRANT_ID      = r_grant;
  assign BUSY          = (r_state == PAYLOAD_ST);
  assign OVERSIZE      = r_oversize;

endmodule

// File: doc/axis_uart_tx_arbiter.md
# axis_uart_tx_arbiter

Round-robin arbiter that shares one UART transmit byte path between N_PORTS AXI-Stream byte sources. It locks onto a source for one whole packet, up to TLAST or a length cap. It prepends a one-byte channel header so the far end can demultiplex. It sits in front of the UART TX serializer, mirroring the RX bridge on the return path, and presents a single registered 8-bit AXI-Stream master.

## Interface
- N_PORTS, 4 — number of requesting streams, 2..16
- HEADER_TAG, 4'hA — upper nibble of the header byte
- MAX_PAYLOAD, 256 — maximum payload bytes per frame, 1..65535
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- S_AXIS_TDATA  in  N_PORTS*8  byte of port i at [8i+7:8i]
- S_AXIS_TVALID  in  N_PORTS  per-port valid
- S_AXIS_TLAST  in  N_PORTS  per-port end of packet
- S_AXIS_TREADY  out  N_PORTS  per-port ready; at most one bit set
- M_AXIS_TDATA  out  8  byte to the UART TX serializer
- M_AXIS_TVALID  out  1  output valid
- M_AXIS_TLAST  out  1  last byte of frame
- M_AXIS_TREADY  in  1  serializer ready
- GRANT_ID  out  4  currently or last granted port
- BUSY  out  1  high while in PAYLOAD
- OVERSIZE  out  1  one-cycle pulse when a frame is cut at MAX_PAYLOAD

## Operation
- Output stage: one-entry register (data, last, valid). "Slot free" = !M_AXIS_TVALID | M_AXIS_TREADY.
- States: IDLE, PAYLOAD.
- IDLE:
  - Condition: slot free and |S_AXIS_TVALID.
  - Winner: the first valid port strictly after last_grant, searched in modulo N_PORTS order.
  - Actions: grant <= winner; output reg <= {HEADER_TAG, winner[3:0]} with TLAST=0 and valid=1; byte_cnt <= 0; go to PAYLOAD.
  - S_AXIS_TREADY is all zero in IDLE.
  - A header is never issued unless the winning port has TVALID high.
- PAYLOAD:
  - S_AXIS_TREADY[grant] = slot free. All other ready bits are 0.
  - On each accepted byte: output reg <= byte, with TLAST = S_AXIS_TLAST[grant] | (byte_cnt == MAX_PAYLOAD-1); byte_cnt increments.
  - When the accepted byte carries the output TLAST: last_grant <= grant, go to IDLE.
  - If the cut came only from the length cap, pulse OVERSIZE. The source's remaining bytes form a new packet at its next grant.
- Slot free with no transfer: M_AXIS_TVALID <= 0.
- While M_AXIS_TVALID=1 and M_AXIS_TREADY=0: M_AXIS_TDATA and M_AXIS_TLAST are held stable.
- byte_cnt is 16 bits. Compare exactly; no wrap is reachable.
- Ports with TVALID low are skipped. A sole requester is re-granted back-to-back.
- A source that drops TVALID mid-packet keeps the grant; the arbiter waits without timeout.

## Timing
- Reset values:
  - M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0
  - S_AXIS_TREADY=0, BUSY=0, OVERSIZE=0, GRANT_ID=0
  - state=IDLE, last_grant=N_PORTS-1, so port 0 wins first
- Reset mid-frame aborts immediately. The frame is truncated with no TLAST, and M_AXIS_TVALID=0 in the cycle after reset is sampled.
- Latency:
  - Request in IDLE with slot free → header valid next cycle.
  - Accepted payload byte → M_AXIS next cycle.
- Throughput is one byte per cycle with no bubble between frames. The IDLE cycle that loads the next header coincides with M accepting the previous TLAST byte.
- Per frame, the output overhead is exactly 1 header byte.
- GRANT_ID updates in the same cycle the header is loaded. BUSY follows state.

## Structure
- uart_bridge_pkg holds:
  - the arb_fsm enum {IDLE_ST, PAYLOAD_ST}
  - the header-byte build function
  - HEADER_TAG default
- Sub-module axis_rr_arbiter_core: combinational round-robin picker. Inputs are request vector and last_grant; outputs are winner index and any_req.
- The FSM, output register and counters live in the top.

## Test plan
- Reset: all outputs 0. Port 2 sends one byte 0x55 with TLAST, M always ready → M sees 0xA2 then 0x55 with TLAST, on consecutive cycles starting one cycle after TVALID.
- Fairness: all 4 ports hold 2-byte packets continuously → header order 0xA0,0xA1,0xA2,0xA3,0xA0. Exactly 3 output bytes per frame, no idle cycles.
- Backpressure: M_AXIS_TREADY toggles randomly 50% → output data and TLAST are stable while stalled. No byte lost or duplicated versus a scoreboard. S_AXIS_TREADY only for the granted port.
- Length cap: MAX_PAYLOAD=4, port 1 sends 6 bytes 0x10..0x15 with TLAST on 0x15:
  - frame 1 is 0xA1,0x10..0x13 with TLAST on 0x13; OVERSIZE pulses once
  - frame 2 is 0xA1,0x14,0x15 with TLAST on 0x15
- Source stall: port 0 deasserts TVALID for 10 cycles mid-packet while port 3 requests → port 3 is not granted until port 0 TLAST. BUSY stays high.
- Reset mid-frame: assert reset after 2 payload bytes → M_AXIS_TVALID=0 next cycle. The next request from port 1 yields header 0xA1, proving last_grant was reset.
